// File: rtl/territory_counter.sv
// ============================================================================
//  Module   : territory_counter
//  Purpose  : Scans the territory RAM once per start pulse, counts the cells
//             owned by each of four players and reports winner and tie.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module territory_counter #(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  output logic [14:0] ram_addr,
  input  logic [2:0]  ram_q,
  output logic        busy,
  output logic        done,
  output logic [14:0] p1_count,
  output logic [14:0] p2_count,
  output logic [14:0] p3_count,
  output logic [14:0] p4_count,
  output logic [1:0]  winner,
  output logic        tie
);

  localparam logic [7:0] c_X_LAST = 8'(X_MAX);
  localparam logic [6:0] c_Y_LAST = 7'(Y_MAX);

  localparam logic [2:0] c_COL_P1 = 3'b001;
  localparam logic [2:0] c_COL_P2 = 3'b010;
  localparam logic [2:0] c_COL_P3 = 3'b100;
  localparam logic [2:0] c_COL_P4 = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SCAN    = 3'd1,
    S_DRAIN   = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic        r_vld;
  logic [14:0] r_p1;
  logic [14:0] r_p2;
  logic [14:0] r_p3;
  logic [14:0] r_p4;
  logic [1:0]  r_step;
  logic [14:0] r_best_cnt;
  logic [1:0]  r_best_idx;
  logic        r_best_tie;
  logic        r_busy;
  logic        r_done;
  logic [1:0]  r_winner;
  logic        r_tie;

  logic        w_launch;
  logic [14:0] w_cand;
  logic [1:0]  w_cand_idx;
  logic [14:0] w_ref_cnt;
  logic [1:0]  w_ref_idx;
  logic        w_ref_tie;

  // DONE's first cycle latches the result and still reports busy, so a start
  // there is ignored like any other start during a scan.
  assign w_launch = start && ((r_state == S_IDLE) ||
                              ((r_state == S_DONE) && !r_busy));

  // Step 0 compares directly against P1: its final count only settles on the
  // DRAIN edge, so the running best cannot be seeded earlier.
  assign w_cand     = (r_step == 2'd0) ? r_p2 : ((r_step == 2'd1) ? r_p3 : r_p4);
  assign w_cand_idx = r_step + 2'd1;
  assign w_ref_cnt  = (r_step == 2'd0) ? r_p1 : r_best_cnt;
  assign w_ref_idx  = (r_step == 2'd0) ? 2'd0 : r_best_idx;
  assign w_ref_tie  = (r_step == 2'd0) ? 1'b0 : r_best_tie;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_x        <= 8'd0;
      r_y        <= 7'd0;
      r_vld      <= 1'b0;
      r_p1       <= 15'd0;
      r_p2       <= 15'd0;
      r_p3       <= 15'd0;
      r_p4       <= 15'd0;
      r_step     <= 2'd0;
      r_best_cnt <= 15'd0;
      r_best_idx <= 2'd0;
      r_best_tie <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_winner   <= 2'd0;
      r_tie      <= 1'b0;
    end else begin
      r_vld <= (r_state == S_SCAN);

      if (r_vld) begin
        case (ram_q)
          c_COL_P1: r_p1 <= r_p1 + 15'd1;
          c_COL_P2: r_p2 <= r_p2 + 15'd1;
          c_COL_P3: r_p3 <= r_p3 + 15'd1;
          c_COL_P4: r_p4 <= r_p4 + 15'd1;
          default: ;
        endcase
      end

      if (w_launch) begin
        r_state <= S_SCAN;
        r_x     <= 8'd0;
        r_y     <= 7'd0;
        r_p1    <= 15'd0;
        r_p2    <= 15'd0;
        r_p3    <= 15'd0;
        r_p4    <= 15'd0;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_SCAN: begin
            if (r_y == c_Y_LAST) begin
              r_y <= 7'd0;
              if (r_x == c_X_LAST) begin
                r_x     <= 8'd0;
                r_state <= S_DRAIN;
              end else begin
                r_x <= r_x + 8'd1;
              end
            end else begin
              r_y <= r_y + 7'd1;
            end
          end

          S_DRAIN: begin
            r_step  <= 2'd0;
            r_state <= S_COMPARE;
          end

          S_COMPARE: begin
            if (w_cand > w_ref_cnt) begin
              r_best_cnt <= w_cand;
              r_best_idx <= w_cand_idx;
              r_best_tie <= 1'b0;
            end else begin
              r_best_cnt <= w_ref_cnt;
              r_best_idx <= w_ref_idx;
              r_best_tie <= w_ref_tie || (w_cand == w_ref_cnt);
            end
            r_step <= r_step + 2'd1;
            if (r_step == 2'd2) begin
              r_state <= S_DONE;
            end
          end

          S_DONE: begin
            if (r_busy) begin
              r_winner <= r_best_idx;
              r_tie    <= r_best_tie;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ram_addr = (r_state == S_SCAN) ? {r_x, r_y} : 15'd0;
  assign busy     = r_busy;
  assign done     = r_done;
  assign p1_count = r_p1;
  assign p2_count = r_p2;
  assign p3_count = r_p3;
  assign p4_count = r_p4;
  assign winner   = r_winner;
  assign tie      = r_tie;

endmodule

`default_nettype wire

// File: tb/tb_territory_counter.sv
// ============================================================================
//  Module   : tb_territory_counter
//  Purpose  : Checks territory_counter (full-size and a reduced 8x6 instance)
//             against constant tables and a counting model of the RAM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_territory_counter;

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic        s_reset, s_start, s_busy, s_done, s_tie;
  logic [14:0] s_addr, s_p1, s_p2, s_p3, s_p4;
  logic [2:0]  s_q;
  logic [1:0]  s_win;
  logic        b_reset, b_start, b_busy, b_done, b_tie;
  logic [14:0] b_addr, b_p1, b_p2, b_p3, b_p4;
  logic [2:0]  b_q;
  logic [1:0]  b_win;

  logic [2:0] s_mem [0:32767];
  logic [2:0] b_mem [0:32767];
  logic [2:0] col [4] = '{3'b001, 3'b010, 3'b100, 3'b110};

  int errors = 0;
  int checks = 0;
  int m_c [4];
  int m_w, m_t;

  territory_counter #(.X_MAX(7), .Y_MAX(5)) u_small (
    .CLOCK_50(CLOCK_50), .reset(s_reset), .start(s_start), .ram_addr(s_addr),
    .ram_q(s_q), .busy(s_busy), .done(s_done), .p1_count(s_p1), .p2_count(s_p2),
    .p3_count(s_p3), .p4_count(s_p4), .winner(s_win), .tie(s_tie));

  territory_counter u_big (
    .CLOCK_50(CLOCK_50), .reset(b_reset), .start(b_start), .ram_addr(b_addr),
    .ram_q(b_q), .busy(b_busy), .done(b_done), .p1_count(b_p1), .p2_count(b_p2),
    .p3_count(b_p3), .p4_count(b_p4), .winner(b_win), .tie(b_tie));

  // Synchronous-read RAMs: data valid the cycle after the address.
  always @(posedge CLOCK_50) begin
    s_q <= s_mem[s_addr];
    b_q <= b_mem[b_addr];
  end

  typedef struct {
    int pat;
    int p1, p2, p3, p4;
    int win;
    int tie;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [14:0] mk(input int x, input int y);
    logic [7:0] xx;
    logic [6:0] yy;
    xx = x[7:0];
    yy = y[6:0];
    return {xx, yy};
  endfunction

  function automatic int xmax(input bit big); return big ? 159 : 7; endfunction
  function automatic int ymax(input bit big); return big ? 119 : 5; endfunction

  task automatic set_start(input bit big, input logic v);
    if (big) b_start = v; else s_start = v;
  endtask

  // Out-of-range cells hold P1 so any address beyond the grid corrupts p1.
  task automatic fill(input bit big, input int pat);
    int xm, ym;
    logic [2:0] c;
    xm = xmax(big);
    ym = ymax(big);
    for (int a = 0; a < 32768; a++) begin
      if (big) b_mem[a] = 3'b001; else s_mem[a] = 3'b001;
    end
    for (int x = 0; x <= xm; x++) begin
      for (int y = 0; y <= ym; y++) begin
        case (pat)
          0: c = 3'b000;
          1: c = 3'b110;
          2: c = ((x == xm) && (y == ym)) ? 3'b001 :
                 (((x + y) % 3 == 0) ? 3'b011 : (((x + y) % 3 == 1) ? 3'b101 : 3'b111));
          3: c = col[x * 4 / (xm + 1)];
          4: c = (y == 0) ? 3'b100 : 3'b010;
          5: c = (x < (xm + 1) / 2) ? 3'b100 : 3'b110;
          6: c = ((x == 0) && (y == 0)) ? 3'b001 : 3'b010;
          7: c = (x == 3 * (xm + 1) / 4) ? 3'b100 : col[x * 4 / (xm + 1)];
          default: c = 3'($urandom_range(0, 7));
        endcase
        if (big) b_mem[mk(x, y)] = c; else s_mem[mk(x, y)] = c;
      end
    end
  endtask

  task automatic model_calc(input bit big);
    logic [2:0] c;
    int mx, n;
    for (int i = 0; i < 4; i++) m_c[i] = 0;
    for (int x = 0; x <= xmax(big); x++) begin
      for (int y = 0; y <= ymax(big); y++) begin
        c = big ? b_mem[mk(x, y)] : s_mem[mk(x, y)];
        for (int i = 0; i < 4; i++) if (c == col[i]) m_c[i]++;
      end
    end
    mx = 0;
    for (int i = 0; i < 4; i++) if (m_c[i] > mx) mx = m_c[i];
    m_w = -1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_c[i] == mx) begin
        n++;
        if (m_w < 0) m_w = i;
      end
    end
    m_t = (n >= 2) ? 1 : 0;
  endtask

  // Pulses start, then follows the scan; caller sits #1 after a rising edge.
  task automatic run_scan(input bit big, input int extra_k, output int lat,
                          output int busy_cyc, output int addr_errs, output int done0);
    int k, cells;
    logic [14:0] exp_a, act_a;
    cells = (xmax(big) + 1) * (ymax(big) + 1);
    busy_cyc = 0;
    addr_errs = 0;
    set_start(big, 1'b1);
    @(posedge CLOCK_50); #1;
    set_start(big, 1'b0);
    done0 = big ? int'(b_done) : int'(s_done);
    k = 0;
    while (1) begin
      if (big ? b_done : s_done) break;
      if (k >= cells + 50) begin
        chk("scan_timeout", k, cells + 5);
        break;
      end
      if (big ? b_busy : s_busy) busy_cyc++;
      exp_a = (k < cells) ? mk(k / (ymax(big) + 1), k % (ymax(big) + 1)) : 15'd0;
      act_a = big ? b_addr : s_addr;
      if (act_a != exp_a) addr_errs++;
      set_start(big, k == extra_k);
      @(posedge CLOCK_50); #1;
      k++;
    end
    set_start(big, 1'b0);
    lat = k;
  endtask

  task automatic chk_result(input string tag, input bit big, input int e1, input int e2,
                            input int e3, input int e4, input int ew, input int et);
    chk({tag, " p1"}, int'(big ? b_p1 : s_p1), e1);
    chk({tag, " p2"}, int'(big ? b_p2 : s_p2), e2);
    chk({tag, " p3"}, int'(big ? b_p3 : s_p3), e3);
    chk({tag, " p4"}, int'(big ? b_p4 : s_p4), e4);
    chk({tag, " winner"}, int'(big ? b_win : s_win), ew);
    chk({tag, " tie"}, int'(big ? b_tie : s_tie), et);
  endtask

  initial begin
    int lat, bc, ae, d0;
    int h [4];
    int hw, ht;

    tbl[0] = '{pat: 0, p1: 0, p2: 0,  p3: 0,  p4: 0,  win: 0, tie: 1};
    tbl[1] = '{pat: 1, p1: 0, p2: 0,  p3: 0,  p4: 48, win: 3, tie: 0};
    tbl[2] = '{pat: 2, p1: 1, p2: 0,  p3: 0,  p4: 0,  win: 0, tie: 0};
    tbl[3] = '{pat: 3, p1: 12, p2: 12, p3: 12, p4: 12, win: 0, tie: 1};
    tbl[4] = '{pat: 4, p1: 0, p2: 40, p3: 8,  p4: 0,  win: 1, tie: 0};
    tbl[5] = '{pat: 5, p1: 0, p2: 0,  p3: 24, p4: 24, win: 2, tie: 1};
    tbl[6] = '{pat: 6, p1: 1, p2: 47, p3: 0,  p4: 0,  win: 1, tie: 0};

    fill(1'b0, 0);
    fill(1'b1, 0);
    s_reset = 1'b1; b_reset = 1'b1; s_start = 1'b0; b_start = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    s_reset = 1'b0; b_reset = 1'b0;
    chk("rst busy", int'(s_busy), 0);
    chk("rst done", int'(s_done), 0);
    chk("rst addr", int'(s_addr), 0);
    chk_result("rst", 1'b0, 0, 0, 0, 0, 0, 0);
    chk("rst big busy", int'(b_busy), 0);
    chk("rst big addr", int'(b_addr), 0);

    // Table-driven patterns on the reduced grid.
    for (int i = 0; i < 7; i++) begin
      fill(1'b0, tbl[i].pat);
      run_scan(1'b0, -1, lat, bc, ae, d0);
      chk($sformatf("tbl%0d latency", i), lat, 53);
      chk($sformatf("tbl%0d busy cycles", i), bc, 53);
      chk($sformatf("tbl%0d addr errors", i), ae, 0);
      chk_result($sformatf("tbl%0d", i), 1'b0, tbl[i].p1, tbl[i].p2, tbl[i].p3,
                 tbl[i].p4, tbl[i].win, tbl[i].tie);
      repeat (2) @(posedge CLOCK_50);
      #1;
    end

    // Random contents against the model; extra starts land at varied points.
    for (int i = 0; i < 4; i++) begin
      fill(1'b0, 8);
      model_calc(1'b0);
      run_scan(1'b0, (i == 0) ? 20 : ((i == 1) ? 48 : ((i == 2) ? 50 : 52)), lat, bc, ae, d0);
      chk($sformatf("rnd%0d latency", i), lat, 53);
      chk_result($sformatf("rnd%0d", i), 1'b0, m_c[0], m_c[1], m_c[2], m_c[3], m_w, m_t);
    end

    // Result holds while RAM changes with no start.
    for (int i = 0; i < 4; i++) h[i] = m_c[i];
    hw = m_w; ht = m_t;
    fill(1'b0, 1);
    repeat (10) @(posedge CLOCK_50);
    #1;
    chk("hold done", int'(s_done), 1);
    chk_result("hold", 1'b0, h[0], h[1], h[2], h[3], hw, ht);

    // Restart from DONE with new contents.
    fill(1'b0, 8);
    model_calc(1'b0);
    run_scan(1'b0, -1, lat, bc, ae, d0);
    chk("restart done drop", d0, 0);
    chk("restart latency", lat, 53);
    chk_result("restart", 1'b0, m_c[0], m_c[1], m_c[2], m_c[3], m_w, m_t);

    // Abort mid-scan with reset (start held too), then a clean full scan.
    fill(1'b0, 8);
    model_calc(1'b0);
    s_start = 1'b1;
    @(posedge CLOCK_50); #1;
    for (int k = 0; k < 20; k++) begin
      s_start = (k == 3) || (k == 10);
      @(posedge CLOCK_50); #1;
    end
    s_start = 1'b1;
    s_reset = 1'b1;
    @(posedge CLOCK_50); #1;
    s_start = 1'b0;
    s_reset = 1'b0;
    chk("abort busy", int'(s_busy), 0);
    chk("abort done", int'(s_done), 0);
    chk("abort addr", int'(s_addr), 0);
    chk_result("abort", 1'b0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("abort idle busy", int'(s_busy), 0);
    run_scan(1'b0, 7, lat, bc, ae, d0);
    chk("after abort latency", lat, 53);
    chk("after abort addr errors", ae, 0);
    chk_result("after abort", 1'b0, m_c[0], m_c[1], m_c[2], m_c[3], m_w, m_t);

    // Full-size grid: column regions with one recoloured column.
    fill(1'b1, 7);
    run_scan(1'b1, 5000, lat, bc, ae, d0);
    chk("big latency", lat, 19205);
    chk("big busy cycles", bc, 19205);
    chk("big addr errors", ae, 0);
    chk_result("big regions", 1'b1, 4800, 4800, 4920, 4680, 2, 0);

    // Full-size grid all P4, restarted straight from DONE.
    fill(1'b1, 1);
    run_scan(1'b1, -1, lat, bc, ae, d0);
    chk("big2 done drop", d0, 0);
    chk("big2 latency", lat, 19205);
    chk("big2 busy cycles", bc, 19205);
    chk("big2 addr errors", ae, 0);
    chk_result("big all p4", 1'b1, 0, 0, 0, 19200, 3, 0);
    chk("big2 idle addr", int'(b_addr), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/territory_counter.md
TERRITORY_COUNTER -- requirements
Module: territory_counter

Interface
REQ-001 SHALL have parameter X_MAX, default 159, last column index scanned.
REQ-002 SHALL have parameter Y_MAX, default 119, last row index scanned.
REQ-003 CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a territory scan (pulsed when the game's running flag falls).
REQ-006 ram_addr  output  15  territory RAM read address {x[7:0], y[6:0]}.
REQ-007 ram_q  input  3  RAM read data; valid exactly one cycle after ram_addr is presented.
REQ-008 busy  output  1  high from scan start until the result is latched.
REQ-009 done  output  1  level; high while the latched result is valid.
REQ-010 p1_count, p2_count, p3_count, p4_count  output  15 each  cells owned per player.
REQ-011 winner  output  2  index of the winning player minus one (0 = P1 ... 3 = P4).
REQ-012 tie  output  1  high when two or more players share the maximum count.

Function
REQ-013 Ownership colour codes SHALL be: P1 = 3'b001, P2 = 3'b010, P3 = 3'b100, P4 = 3'b110; any other value counts for nobody.
REQ-014 The FSM SHALL have states IDLE, SCAN, DRAIN, COMPARE, DONE.
REQ-015 IDLE: start=1 -> SCAN on the next edge; all four counts cleared to 0 on that same edge; busy=1, done=0 from the following cycle.
REQ-016 SCAN: ram_addr SHALL walk y fastest (0..Y_MAX), then x (0..X_MAX), one address per cycle, starting at {0,0}; y values above Y_MAX are never issued.
REQ-017 SCAN lasts exactly (X_MAX+1)*(Y_MAX+1) cycles (19200 by default); after issuing {X_MAX,Y_MAX} the FSM SHALL enter DRAIN.
REQ-018 A one-cycle data-valid pipeline bit SHALL track each issued address; on the cycle its ram_q is valid, the matching count SHALL increment by exactly 1.
REQ-019 DRAIN: one cycle to accumulate the last read, then COMPARE.
REQ-020 COMPARE: three cycles, sequentially comparing P2, P3, P4 against the running best (initialised to P1); a strictly greater count replaces the best, equal count keeps the lower index and sets a tie flag; tie flag clears when a strictly greater count is found.
REQ-021 After COMPARE the FSM SHALL enter DONE, latching winner and tie; busy=0, done=1.
REQ-022 Total latency: start sampled at edge N -> done first high in the cycle after edge N+19205 (default parameters).
REQ-023 start while busy SHALL be ignored.
REQ-024 start in DONE SHALL restart exactly as from IDLE (counts cleared, done drops next cycle).
REQ-025 Counts SHALL not overflow: 15 bits hold the 19200 maximum; no saturation logic required.
REQ-026 ram_addr SHALL hold 0 outside SCAN.
REQ-027 Outputs p*_count, winner, tie SHALL hold their values from DONE until the next start or reset.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, busy=0, done=0, tie=0, winner=0, all counts 0, ram_addr=0, pipeline valid=0, taking priority over start.
REQ-029 reset during SCAN, DRAIN or COMPARE SHALL abort the scan with no partial result kept; a later start performs a full fresh scan.

Verification
REQ-030 RAM model all 3'b000, start pulse -> after 19205 cycles done=1, all counts 0, winner=0, tie=1.
REQ-031 RAM model: x<40 -> 001, 40<=x<80 -> 010, 80<=x<120 -> 100, x>=120 -> 110, except P3 region also one extra column recoloured to P3 (x=120 -> 100) -> p1=4800, p2=4800, p3=4920, p4=4680, winner=2, tie=0.
REQ-032 RAM model all 3'b110 -> p4_count=19200, others 0, winner=3, tie=0; check busy high exactly 19205 cycles and ram_addr sequence {0,0},{0,1}..{0,119},{1,0}..{159,119}.
REQ-033 Cells with codes 011, 101, 111 only plus a single 001 at {159,119} -> p1_count=1 (last-address pipeline check), others 0, winner=0.
REQ-034 Assert reset at cycle 5000 of a scan, then start again -> counts equal a clean full scan; extra start pulses during busy have no effect.
REQ-035 start asserted in DONE with changed RAM contents -> done drops next cycle, new counts reflect new contents only.
